// File: rtl/cache_req_pkg.sv
// Shared state encodings, funct3 constants and access-size helpers for cache_req_unit.
package cache_req_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StRsp  = 2'd3;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  // funct3 3/6/7 fall through to word accesses.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    if (is_byte(f3)) return 1'b0;
    if (is_half(f3)) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/cache_req_lane.sv
// Combinational byte/halfword lane logic: store merge into a read word, load extract and extend.
module cache_req_lane
  import cache_req_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    merged    = word;
    load_data = word;
    lane_b    = word[{offset, 3'b000} +: 8];
    lane_h    = word[{offset[1], 4'b0000} +: 16];
    if (is_byte(funct3)) begin
      merged[{offset, 3'b000} +: 8] = wdata[7:0];
      load_data = (funct3 == F3_B) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
    end else if (is_half(funct3)) begin
      // Odd halfword addresses are force-aligned: only offset[1] selects the lane.
      merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      load_data = (funct3 == F3_H) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
    end else begin
      merged = wdata;
    end
  end

endmodule

// File: rtl/cache_req_unit.sv
// Load/store front end for the direct-mapped data cache; optional misalignment
// trapping is enabled by defining CACHE_REQ_ALIGN_CHECK_EN.
module cache_req_unit
  import cache_req_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] c_addr,
  output logic [31:0] c_din,
  output logic        c_re,
  output logic        c_we,
  input  logic        c_done,
  input  logic [31:0] c_dout
);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        err_d;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic        accept;

  assign accept = (state_q == StIdle) && req_valid;

`ifdef CACHE_REQ_ALIGN_CHECK_EN
  assign err_d = misaligned(req_funct3, req_addr[1:0]);
`else
  assign err_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (err_d) begin
            state_d = StRsp;
          end else if (req_we && !is_byte(req_funct3) && !is_half(req_funct3)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    if (c_done) state_d = we_q ? StWr : StRsp;
      StWr:    if (c_done) state_d = StRsp;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      addr_q   <= 32'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      data_q   <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
        err_q    <= err_d;
      end
      if ((state_q == StRd) && c_done) begin
        data_q <= c_dout;
      end
    end
  end

  cache_req_lane u_lane (
    .funct3    (funct3_q),
    .offset    (addr_q[1:0]),
    .word      (data_q),
    .wdata     (wdata_q),
    .merged    (merged),
    .load_data (load_data)
  );

  // All cache-facing outputs decode from registers only, so they stay stable while c_re/c_we wait.
  assign req_ready = (state_q == StIdle);
  assign c_re      = (state_q == StRd);
  assign c_we      = (state_q == StWr);
  assign c_addr    = {addr_q[31:2], 2'b00};
  assign c_din     = merged;
  assign rsp_valid = (state_q == StRsp);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_cache_req_unit.sv
// Directed bench for cache_req_unit with a small hit/miss cache model.
module tb_cache_req_unit;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] c_addr;
  logic [31:0] c_din;
  logic        c_re;
  logic        c_we;
  logic        c_done;
  logic [31:0] c_dout;

  int errs   = 0;
  int checks = 0;

  // Cache model: done after miss_cycles waiting cycles per access.
  int          miss_cycles = 0;
  int          wait_cnt;
  logic [31:0] mem_word = 32'h0;
  int          acc_total;
  // Monitor totals.
  int          re_cyc, we_cyc, addr_bad, both_cnt, rsp_cnt;
  logic [31:0] last_din;
  logic [31:0] exp_caddr = 32'h0;

  cache_req_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .c_addr     (c_addr),
    .c_din      (c_din),
    .c_re       (c_re),
    .c_we       (c_we),
    .c_done     (c_done),
    .c_dout     (c_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign c_done = (c_re || c_we) && (wait_cnt >= miss_cycles);
  assign c_dout = mem_word;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt  <= 0;
      acc_total <= 0;
    end else begin
      if (!(c_re || c_we) || c_done) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      if ((c_re || c_we) && c_done) acc_total <= acc_total + 1;
    end
  end

  initial begin
    re_cyc = 0; we_cyc = 0; addr_bad = 0; both_cnt = 0; rsp_cnt = 0; last_din = 32'h0;
  end

  always @(negedge clk) begin
    if (c_re) re_cyc <= re_cyc + 1;
    if (c_we) begin
      we_cyc   <= we_cyc + 1;
      last_din <= c_din;
    end
    if ((c_re || c_we) && c_addr != exp_caddr) addr_bad <= addr_bad + 1;
    if (c_re && c_we) both_cnt <= both_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request; lat counts cycles after acceptance until rsp_valid (-1 on timeout).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output int d_re, output int d_we, output int d_acc,
                        output int d_bad);
    int re0, we0, acc0, bad0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    exp_caddr = {a[31:2], 2'b00};
    check_eq("ready_before_req", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    re0 = re_cyc; we0 = we_cyc; acc0 = acc_total; bad0 = addr_bad;
    lat = -1; rd = 32'h0; err = 1'b0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; err = rsp_err;
        break;
      end
    end
    if (lat < 0) check_eq("rsp_timeout", 32'h0, 32'h1);
    @(negedge clk);
    check_eq("rsp_one_pulse", {31'h0, rsp_valid}, 32'h0);
    d_re = re_cyc - re0; d_we = we_cyc - we0; d_acc = acc_total - acc0; d_bad = addr_bad - bad0;
  endtask

  int lat, d_re, d_we, d_acc, d_bad, rsp0;
  logic [31:0] rd;
  logic err;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check_eq("rst_c_re_we", {30'h0, c_re, c_we}, 32'h0);
    check_eq("rst_c_addr", c_addr, 32'h0);
    check_eq("rst_c_din", c_din, 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    rstn = 1'b1;

    // lw hit
    mem_word = 32'h8899AABB;
    do_req(1'b0, 3'd2, 32'h104, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("lw_lat", lat, 2);
    check_eq("lw_rdata", rd, 32'h8899AABB);
    check_eq("lw_re_cycles", d_re, 1);
    check_eq("lw_we_cycles", d_we, 0);
    check_eq("lw_accesses", d_acc, 1);

    // sub-word loads
    mem_word = 32'h80123456;
    do_req(1'b0, 3'd0, 32'h107, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("lb_rdata", rd, 32'hFFFFFF80);
    check_eq("lb_lat", lat, 2);
    do_req(1'b0, 3'd4, 32'h107, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("lbu_rdata", rd, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h106, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("lh_rdata", rd, 32'hFFFF8012);
    do_req(1'b0, 3'd5, 32'h104, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("lhu_rdata", rd, 32'h00003456);
    do_req(1'b0, 3'd0, 32'h104, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("lb_pos_rdata", rd, 32'h00000056);

    // sb read-merge-write
    mem_word = 32'h11223344;
    do_req(1'b1, 3'd0, 32'h101, 32'h000000A5, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("sb_lat", lat, 3);
    check_eq("sb_din", last_din, 32'h1122A544);
    check_eq("sb_addr_stable", d_bad, 0);
    check_eq("sb_re_we", {d_re[15:0], d_we[15:0]}, {16'd1, 16'd1});
    check_eq("sb_accesses", d_acc, 2);
    check_eq("sb_rdata_zero", rd, 32'h0);

    do_req(1'b1, 3'd1, 32'h102, 32'h1234BEEF, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("sh_din", last_din, 32'hBEEF3344);
    check_eq("sh_lat", lat, 3);

    do_req(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("sw_lat", lat, 2);
    check_eq("sw_din", last_din, 32'hDEADBEEF);
    check_eq("sw_no_read", d_re, 0);

    // lw miss: 34 stall cycles
    miss_cycles = 34;
    mem_word = 32'hCAFEF00D;
    do_req(1'b0, 3'd2, 32'h3F0, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("miss_lat", lat, 36);
    check_eq("miss_re_cycles", d_re, 35);
    check_eq("miss_addr_stable", d_bad, 0);
    check_eq("miss_accesses", d_acc, 1);
    check_eq("miss_rdata", rd, 32'hCAFEF00D);

    // reset during WR
    miss_cycles = 10;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h300;
    req_wdata = 32'h55AA55AA; exp_caddr = 32'h300;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp0 = rsp_cnt;
    repeat (3) @(negedge clk);
    check_eq("wr_before_reset", {31'h0, c_we}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check_eq("reset_c_we_drop", {30'h0, c_re, c_we}, 32'h0);
    check_eq("reset_idle", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    miss_cycles = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_no_rsp", rsp_cnt - rsp0, 0);
    mem_word = 32'h12345678;
    do_req(1'b0, 3'd2, 32'h104, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("post_reset_lat", lat, 2);
    check_eq("post_reset_rdata", rd, 32'h12345678);

    // misaligned word load
    mem_word = 32'hA1B2C3D4;
`ifdef CACHE_REQ_ALIGN_CHECK_EN
    do_req(1'b0, 3'd2, 32'h102, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("mis_lat", lat, 1);
    check_eq("mis_err", {31'h0, err}, 32'h1);
    check_eq("mis_rdata", rd, 32'h0);
    check_eq("mis_no_access", d_re + d_we, 0);
`else
    do_req(1'b0, 3'd2, 32'h102, 32'h0, lat, rd, err, d_re, d_we, d_acc, d_bad);
    check_eq("mis_lat", lat, 2);
    check_eq("mis_err", {31'h0, err}, 32'h0);
    check_eq("mis_rdata", rd, 32'hA1B2C3D4);
`endif

    check_eq("re_we_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
